// File: rtl/queens_board_checker_pkg.sv
// +------------------------------------------------------------------+
// | queens_pkg : shared types for the N-queens board checker          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package queens_pkg;

  localparam int N_QUEENS = 8;

  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_ONEHOT = 2'd1,
    ERR_COL    = 2'd2,
    ERR_DIAG   = 2'd3
  } qchk_err_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } qchk_state_e;

endpackage

`default_nettype wire

// File: rtl/queens_board_checker_if.sv
// +------------------------------------------------------------------+
// | queens_board_checker_if : row stream + verdict bundle             |
// | Rev 1.0   (ok_cnt/fail_cnt present only with QCHK_STATS_EN)       |
// +------------------------------------------------------------------+
`default_nettype none

interface queens_board_checker_if
  import queens_pkg::*;
#(
  parameter int N  = N_QUEENS,
  parameter int RW = $clog2(N)
) ();

  logic          start;
  logic          row_valid;
  logic [N-1:0]  row_data;
  logic          row_ready;
  logic          busy;
  logic          done;
  logic          board_ok;
  logic [1:0]    err_code;
  logic [RW-1:0] err_row;
`ifdef QCHK_STATS_EN
  logic [15:0]   ok_cnt;
  logic [15:0]   fail_cnt;
`endif

  modport master (
    output start, row_valid, row_data,
    input  row_ready, busy, done, board_ok, err_code, err_row
`ifdef QCHK_STATS_EN
    , input ok_cnt, fail_cnt
`endif
  );

  modport slave (
    input  start, row_valid, row_data,
    output row_ready, busy, done, board_ok, err_code, err_row
`ifdef QCHK_STATS_EN
    , output ok_cnt, fail_cnt
`endif
  );

endinterface

`default_nettype wire

// File: rtl/queens_board_checker_row_check.sv
// +------------------------------------------------------------------+
// | queens_row_check : classify one row against the attack masks      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module queens_row_check
  import queens_pkg::*;
#(
  parameter int N = N_QUEENS
) (
  input  logic [N-1:0] row_i,
  input  logic [N-1:0] col_m_i,
  input  logic [N-1:0] dl_m_i,
  input  logic [N-1:0] dr_m_i,
  output qchk_err_e    err_o
);

  logic onehot_w;

  // Clearing the lowest set bit leaves zero only for a single-bit value.
  assign onehot_w = (row_i != '0) && ((row_i & (row_i - N'(1))) == '0);

  always_comb begin
    err_o = ERR_NONE;
    if (!onehot_w) begin
      err_o = ERR_ONEHOT;
    end else if ((row_i & col_m_i) != '0) begin
      err_o = ERR_COL;
    end else if ((row_i & (dl_m_i | dr_m_i)) != '0) begin
      err_o = ERR_DIAG;
    end
  end

endmodule

`default_nettype wire

// File: rtl/queens_board_checker.sv
// +------------------------------------------------------------------+
// | queens_board_checker : incremental N-queens board audit           |
// | Rev 1.0   (optional pass/fail counters: QCHK_STATS_EN)            |
// +------------------------------------------------------------------+
`default_nettype none

module queens_board_checker
  import queens_pkg::*;
#(
  parameter int N  = N_QUEENS,
  parameter int RW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  queens_board_checker_if.slave bus
);

  qchk_state_e   state_q, state_d;
  logic [RW-1:0] cnt_q;
  logic [N-1:0]  col_m_q, dl_m_q, dr_m_q;
  qchk_err_e     err_code_q;
  logic [RW-1:0] err_row_q;
  logic          board_ok_q;

  qchk_err_e     row_err_w;
  qchk_err_e     err_next_w;
  logic          start_acc_w;
  logic          xfer_w;
  logic          last_w;

  queens_row_check #(.N(N)) u_row_check (
    .row_i   (bus.row_data),
    .col_m_i (col_m_q),
    .dl_m_i  (dl_m_q),
    .dr_m_i  (dr_m_q),
    .err_o   (row_err_w)
  );

  assign start_acc_w = (state_q == IDLE) && bus.start;
  assign xfer_w      = (state_q == RECV) && bus.row_valid;
  assign last_w      = (cnt_q == RW'(N - 1));
  assign err_next_w  = (err_code_q != ERR_NONE) ? err_code_q : row_err_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RECV;
      RECV:    if (xfer_w && last_w) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.row_ready = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state_q)
      RECV: begin
        bus.row_ready = 1'b1;
        bus.busy      = 1'b1;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // Error fields freeze on the first offence; masks keep tracking every row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      col_m_q    <= '0;
      dl_m_q     <= '0;
      dr_m_q     <= '0;
      err_code_q <= ERR_NONE;
      err_row_q  <= '0;
      board_ok_q <= 1'b0;
    end else if (start_acc_w) begin
      cnt_q      <= '0;
      col_m_q    <= '0;
      dl_m_q     <= '0;
      dr_m_q     <= '0;
      err_code_q <= ERR_NONE;
      err_row_q  <= '0;
      board_ok_q <= 1'b0;
    end else if (xfer_w) begin
      col_m_q    <= col_m_q | bus.row_data;
      dl_m_q     <= (dl_m_q | bus.row_data) << 1;
      dr_m_q     <= (dr_m_q | bus.row_data) >> 1;
      err_code_q <= err_next_w;
      if (!last_w) begin
        cnt_q <= cnt_q + RW'(1);
      end
      if ((err_code_q == ERR_NONE) && (row_err_w != ERR_NONE)) begin
        err_row_q <= cnt_q;
      end
      if (last_w) begin
        board_ok_q <= (err_next_w == ERR_NONE);
      end
    end
  end

  assign bus.board_ok = board_ok_q;
  assign bus.err_code = err_code_q;
  assign bus.err_row  = err_row_q;

`ifdef QCHK_STATS_EN
  logic [15:0] ok_cnt_q;
  logic [15:0] fail_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_cnt_q   <= '0;
      fail_cnt_q <= '0;
    end else if (state_q == DONE) begin
      if (board_ok_q) begin
        if (ok_cnt_q != STAT_MAX) ok_cnt_q <= ok_cnt_q + 16'd1;
      end else begin
        if (fail_cnt_q != STAT_MAX) fail_cnt_q <= fail_cnt_q + 16'd1;
      end
    end
  end

  assign bus.ok_cnt   = ok_cnt_q;
  assign bus.fail_cnt = fail_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_queens_board_checker.sv
// +------------------------------------------------------------------+
// | tb_queens_board_checker : randomized bench with board-rule model  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_queens_board_checker;
  import queens_pkg::*;

  localparam int N  = N_QUEENS;
  localparam int RW = $clog2(N);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  queens_board_checker_if #(.N(N)) bus ();

  queens_board_checker #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int m_ok  = 0;
  int m_fail = 0;
  int exp_code;
  int exp_row;
  logic [N-1:0] brd [N];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Board rules: a row must hold exactly one queen, and no queen may share a
  // column or a diagonal with any queen in an earlier row. First error wins.
  function automatic void model();
    int  code;
    int  c;
    bit  colh;
    bit  diag;
    exp_code = 0;
    exp_row  = 0;
    for (int r = 0; r < N; r++) begin
      code = 0;
      if ($countones(brd[r]) != 1) begin
        code = 1;
      end else begin
        c = 0; colh = 0; diag = 0;
        for (int k = 0; k < N; k++) if (brd[r][k]) c = k;
        for (int p = 0; p < r; p++) begin
          for (int k = 0; k < N; k++) begin
            if (brd[p][k]) begin
              if (k == c) colh = 1;
              else if ((k - c) == (r - p) || (c - k) == (r - p)) diag = 1;
            end
          end
        end
        code = colh ? 2 : (diag ? 3 : 0);
      end
      if (exp_code == 0 && code != 0) begin
        exp_code = code;
        exp_row  = r;
      end
    end
  endfunction

  task automatic load_valid();
    brd[0] = 8'h01; brd[1] = 8'h10; brd[2] = 8'h80; brd[3] = 8'h20;
    brd[4] = 8'h04; brd[5] = 8'h40; brd[6] = 8'h02; brd[7] = 8'h08;
  endtask

  task automatic run_board(input int gap_max, input bit poke_start);
    int  cyc;
    int  g;
    bit  seen;
    model();
    bus.start = 1'b1;
    cyc = 1;
    tick(); cyc++;
    bus.start = 1'b0;
    check("start_busy", bus.busy, 1);
    check("start_clr_ok", bus.board_ok, 0);
    check("start_clr_err", bus.err_code, 0);
    for (int r = 0; r < N; r++) begin
      g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
      for (int i = 0; i < g; i++) begin
        bus.row_valid = 1'b0;
        tick(); cyc++;
        check("gap_busy", bus.busy, 1);
      end
      bus.row_valid = 1'b1;
      bus.row_data  = brd[r];
      if (poke_start && r == 3) bus.start = 1'b1;
      check("row_ready", bus.row_ready, 1);
      tick(); cyc++;
      bus.start = 1'b0;
    end
    bus.row_valid = 1'b0;
    bus.row_data  = N'($urandom);
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else begin tick(); cyc++; end
    end
    check("done_seen", seen, 1);
    if (seen) begin
      if (gap_max == 0) check("latency", cyc, N + 2);
      check("err_code", bus.err_code, exp_code);
      check("err_row", bus.err_row, exp_row);
      check("board_ok", bus.board_ok, (exp_code == 0));
      check("done_busy", bus.busy, 0);
      if (exp_code == 0) m_ok++; else m_fail++;
      tick();
      check("done_pulse", bus.done, 0);
      check("ok_held", bus.board_ok, (exp_code == 0));
`ifdef QCHK_STATS_EN
      check("ok_cnt", bus.ok_cnt, m_ok);
      check("fail_cnt", bus.fail_cnt, m_fail);
`endif
    end
  endtask

  task automatic rand_board(input bit perm);
    int cols [N];
    int j, t;
    for (int i = 0; i < N; i++) cols[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = cols[i]; cols[i] = cols[j]; cols[j] = t;
    end
    for (int r = 0; r < N; r++) begin
      if (perm) brd[r] = N'(1) << cols[r];
      else if ($urandom_range(3, 0) == 0) brd[r] = N'($urandom);
      else brd[r] = N'(1) << $urandom_range(N - 1, 0);
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.row_valid = 1'b0;
    bus.row_data  = '0;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ready", bus.row_ready, 0);
    check("rst_ok", bus.board_ok, 0);
    check("rst_code", bus.err_code, 0);
    check("rst_row", bus.err_row, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    load_valid();
    run_board(0, 0);

    brd[0] = 8'h01; brd[1] = 8'h01; brd[2] = 8'h04; brd[3] = 8'h08;
    brd[4] = 8'h10; brd[5] = 8'h20; brd[6] = 8'h40; brd[7] = 8'h80;
    run_board(0, 0);

    brd[0] = 8'h01; brd[1] = 8'h04; brd[2] = 8'h02;
    run_board(0, 0);
    brd[1] = 8'h02; brd[2] = 8'h04;
    run_board(0, 0);

    load_valid(); brd[3] = 8'h03; brd[5] = 8'h01;
    run_board(0, 0);
    load_valid(); brd[3] = 8'h00; brd[5] = 8'h10;
    run_board(0, 0);

    for (int i = 0; i < 4; i++) begin
      load_valid();
      run_board(3, 0);
    end
    load_valid();
    run_board(2, 1);

    load_valid();
    bus.row_valid = 1'b1;
    bus.row_data  = brd[0];
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_ready", bus.row_ready, 0);
      check("idle_busy", bus.busy, 0);
    end
    run_board(0, 0);

    for (int i = 0; i < 24; i++) begin
      rand_board(i[0]);
      run_board((i % 3 == 0) ? 2 : 0, 0);
    end

    load_valid();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      bus.row_valid = 1'b1; bus.row_data = brd[r];
      tick();
    end
    bus.row_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_ready", bus.row_ready, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_code", bus.err_code, 0);
    check("mid_rst_row", bus.err_row, 0);
    m_ok = 0; m_fail = 0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_done", bus.done, 0);
    end
    run_board(0, 0);
`ifdef QCHK_STATS_EN
    check("post_rst_ok_cnt", bus.ok_cnt, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
